// File: rtl/scroll_scheduler.sv
// scroll_scheduler: run/crash sequencer driving ground scroll, speed ramp and score per video frame
module scroll_scheduler #(
  parameter int GROUND_PERIOD     = 160,
  parameter int INIT_SPEED        = 1,
  parameter int MAX_SPEED         = 8,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int SCORE_DIV         = 6,
  parameter int CRASH_HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        collision,
  output logic        game_status,
  output logic        crashed,
  output logic [9:0]  ground_position,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        frame_update
);
  localparam int SW = SPEED_STEP_FRAMES > 1 ? $clog2(SPEED_STEP_FRAMES) : 1;
  localparam int DW = SCORE_DIV > 1 ? $clog2(SCORE_DIV) : 1;
  localparam int HW = $clog2(CRASH_HOLD_FRAMES + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(SPEED_STEP_FRAMES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCORE_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(CRASH_HOLD_FRAMES);
  localparam logic [10:0]   PERIOD    = 11'(GROUND_PERIOD);
  typedef enum logic [1:0] {IDLE, RUNNING, CRASHED} state_t;
  state_t state, state_nxt;
  logic start_q, start_pressed, go, crash, advance;
  logic [SW-1:0] step_cnt;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hold_cnt;
  logic [10:0] sum;
  always_comb begin
    start_pressed = start_btn & ~start_q;
    go = start_pressed & ((state == IDLE) | ((state == CRASHED) & (hold_cnt == HOLD_MAX)));
    crash = (state == RUNNING) & collision;
    advance = (state == RUNNING) & ~collision & frame_tick;
    state_nxt = go ? RUNNING : crash ? CRASHED : state;
    sum = 11'(ground_position) + 11'(speed);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      start_q <= 1'b0;
      game_status <= 1'b0;
      crashed <= 1'b0;
      frame_update <= 1'b0;
      ground_position <= '0;
      speed <= 4'(INIT_SPEED);
      score <= '0;
      step_cnt <= '0;
      div_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      start_q <= start_btn;
      game_status <= state_nxt == RUNNING;
      crashed <= state_nxt == CRASHED;
      frame_update <= advance;
      if (go) begin
        ground_position <= '0;
        speed <= 4'(INIT_SPEED);
        score <= '0;
        step_cnt <= '0;
        div_cnt <= '0;
        hold_cnt <= '0;
      end else if (crash) begin
        hold_cnt <= '0;
      end else if (advance) begin
        ground_position <= sum >= PERIOD ? 10'(sum - PERIOD) : sum[9:0];
        step_cnt <= step_cnt == STEP_LAST ? '0 : step_cnt + 1'b1;
        div_cnt <= div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
        if (step_cnt == STEP_LAST && speed < 4'(MAX_SPEED))
          speed <= speed + 1'b1;
        if (div_cnt == DIV_LAST && score != 16'hFFFF)
          score <= score + 1'b1;
      end else if (state == CRASHED && frame_tick && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scroll_scheduler.sv
// tb_scroll_scheduler: table-driven directed checks of the scroll scheduler
module tb_scroll_scheduler;
  logic clk = 1'b0;
  logic rst, frame_tick, start_btn, collision;
  logic game_status, crashed, frame_update;
  logic [9:0] ground_position;
  logic [3:0] speed;
  logic [15:0] score;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  scroll_scheduler dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .collision(collision),
    .game_status(game_status),
    .crashed(crashed),
    .ground_position(ground_position),
    .speed(speed),
    .score(score),
    .frame_update(frame_update)
  );
  typedef struct {
    logic r, s, c, t;
    int n;
    logic gs, cr;
    logic [9:0] gp;
    logic [3:0] sp;
    logic [15:0] sc;
    logic fu;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic r, logic s, logic c, logic t, int n, logic gs, logic cr,
                              int gp, int sp, int sc, logic fu);
    vec_t x;
    x.r = r; x.s = s; x.c = c; x.t = t; x.n = n;
    x.gs = gs; x.cr = cr; x.gp = 10'(gp); x.sp = 4'(sp); x.sc = 16'(sc); x.fu = fu;
    return x;
  endfunction
  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; collision = 1'b0;
    v.push_back(mk(1, 0, 0, 0, 2,    0, 0, 0,   1, 0,    0));
    v.push_back(mk(0, 1, 0, 0, 5,    1, 0, 0,   1, 0,    0));
    v.push_back(mk(0, 0, 0, 1, 1,    1, 0, 1,   1, 0,    1));
    v.push_back(mk(0, 0, 0, 0, 1,    1, 0, 1,   1, 0,    0));
    v.push_back(mk(0, 0, 0, 1, 158,  1, 0, 159, 1, 26,   1));
    v.push_back(mk(0, 0, 0, 1, 1,    1, 0, 0,   1, 26,   1));
    v.push_back(mk(0, 0, 0, 0, 1,    1, 0, 0,   1, 26,   0));
    v.push_back(mk(0, 0, 0, 1, 440,  1, 0, 120, 2, 100,  1));
    v.push_back(mk(0, 0, 0, 1, 3000, 1, 0, 120, 7, 600,  1));
    v.push_back(mk(0, 0, 0, 1, 5,    1, 0, 155, 7, 600,  1));
    v.push_back(mk(0, 0, 0, 1, 1,    1, 0, 2,   7, 601,  1));
    v.push_back(mk(0, 0, 0, 1, 594,  1, 0, 0,   8, 700,  1));
    v.push_back(mk(0, 0, 0, 1, 19,   1, 0, 152, 8, 703,  1));
    v.push_back(mk(0, 0, 0, 1, 1,    1, 0, 0,   8, 703,  1));
    v.push_back(mk(0, 0, 0, 1, 1780, 1, 0, 0,   8, 1000, 1));
    v.push_back(mk(0, 0, 1, 1, 1,    0, 1, 0,   8, 1000, 0));
    v.push_back(mk(0, 0, 0, 1, 10,   0, 1, 0,   8, 1000, 0));
    v.push_back(mk(0, 1, 0, 0, 1,    0, 1, 0,   8, 1000, 0));
    v.push_back(mk(0, 0, 0, 1, 49,   0, 1, 0,   8, 1000, 0));
    v.push_back(mk(0, 1, 0, 0, 1,    0, 1, 0,   8, 1000, 0));
    v.push_back(mk(0, 0, 0, 1, 1,    0, 1, 0,   8, 1000, 0));
    v.push_back(mk(0, 1, 0, 0, 1,    1, 0, 0,   1, 0,    0));
    v.push_back(mk(0, 1, 0, 1, 1,    1, 0, 1,   1, 0,    1));
    v.push_back(mk(0, 0, 0, 1, 36,   1, 0, 37,  1, 6,    1));
    v.push_back(mk(0, 0, 1, 1, 1,    0, 1, 37,  1, 6,    0));
    v.push_back(mk(0, 0, 0, 1, 60,   0, 1, 37,  1, 6,    0));
    v.push_back(mk(0, 1, 0, 1, 1,    1, 0, 0,   1, 0,    0));
    v.push_back(mk(0, 0, 0, 1, 1,    1, 0, 1,   1, 0,    1));
    v.push_back(mk(0, 0, 0, 1, 4,    1, 0, 5,   1, 0,    1));
    v.push_back(mk(1, 0, 0, 1, 1,    0, 0, 0,   1, 0,    0));
    v.push_back(mk(0, 0, 0, 1, 1,    0, 0, 0,   1, 0,    0));
    v.push_back(mk(0, 1, 0, 0, 1,    1, 0, 0,   1, 0,    0));
    @(negedge clk);
    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].r; start_btn = v[i].s; collision = v[i].c; frame_tick = v[i].t;
      repeat (v[i].n) @(negedge clk);
      checks++;
      if (game_status !== v[i].gs || crashed !== v[i].cr || ground_position !== v[i].gp ||
          speed !== v[i].sp || score !== v[i].sc || frame_update !== v[i].fu) begin
        errors++;
        $display("FAIL vec%0d: got gs=%b cr=%b gp=%0d sp=%0d sc=%0d fu=%b, want gs=%b cr=%b gp=%0d sp=%0d sc=%0d fu=%b",
                 i, game_status, crashed, ground_position, speed, score, frame_update,
                 v[i].gs, v[i].cr, v[i].gp, v[i].sp, v[i].sc, v[i].fu);
      end
    end
    start_btn = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (frame_update !== 1'b0 || ground_position !== 10'd1) begin
        errors++;
        $display("FAIL strobe_width cyc%0d: got fu=%b gp=%0d, want fu=0 gp=1", k, frame_update, ground_position);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
